// File: rtl/periph_lock_rr_scheduler.sv
`default_nettype none
// ============================================================================
// periph_lock_rr_scheduler : round-robin slave-port scheduler with master lock
//                            and lock watchdog
// Revision : 1.0
// ============================================================================
module periph_lock_rr_scheduler #(
   parameter int N_MASTER   = 16,
   parameter int LOG_MASTER = $clog2(N_MASTER),
   parameter int MAX_LOCK   = 64,
   parameter int CNT_WIDTH  = $clog2(MAX_LOCK)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_MASTER-1:0]   req_i,
   input  logic [N_MASTER-1:0]   lock_i,
   input  logic                  slv_gnt_i,
   output logic                  slv_req_o,
   output logic [LOG_MASTER-1:0] sel_o,
   output logic [N_MASTER-1:0]   gnt_o,
   output logic                  lock_active_o,
   output logic [LOG_MASTER-1:0] owner_o,
   output logic                  lock_abort_o
);

   typedef enum logic [0:0] {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [LOG_MASTER:0]   N_EXT    = (LOG_MASTER+1)'(N_MASTER);
   localparam logic [LOG_MASTER-1:0] LAST_IDX = LOG_MASTER'(N_MASTER-1);
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = CNT_WIDTH'(MAX_LOCK-1);

   state_t                state;
   logic [LOG_MASTER-1:0] rr_ptr;
   logic [CNT_WIDTH-1:0]  lock_cnt;
   logic [LOG_MASTER-1:0] winner;
   logic [LOG_MASTER:0]   cand;
   logic                  found;
   logic                  owner_req;
   logic                  owner_lock;
   logic                  handshake;

   function automatic logic [LOG_MASTER-1:0] next_idx(input logic [LOG_MASTER-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + 1'b1;
   endfunction

   // Circular search starting at rr_ptr; the wrap is explicit so that
   // non-power-of-two master counts never alias onto missing indices.
   always_comb begin
      winner = rr_ptr;
      found  = 1'b0;
      cand   = '0;
      for (int k = 0; k < N_MASTER; k++) begin
         cand = {1'b0, rr_ptr} + (LOG_MASTER+1)'(k);
         if (cand >= N_EXT) cand = cand - N_EXT;
         if (!found && req_i[cand[LOG_MASTER-1:0]]) begin
            found  = 1'b1;
            winner = cand[LOG_MASTER-1:0];
         end
      end
   end

   always_comb begin
      owner_req  = req_i[owner_o];
      owner_lock = lock_i[owner_o];
      gnt_o      = '0;
      if (state == LOCKED) begin
         sel_o     = owner_o;
         slv_req_o = owner_req & ~rst;
      end else begin
         sel_o     = winner;
         slv_req_o = (|req_i) & ~rst;
      end
      handshake = slv_req_o & slv_gnt_i;
      if (handshake) gnt_o[sel_o] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ARB;
         rr_ptr        <= '0;
         lock_cnt      <= '0;
         owner_o       <= '0;
         lock_active_o <= 1'b0;
         lock_abort_o  <= 1'b0;
      end else begin
         lock_abort_o <= 1'b0;
         case (state)
            ARB: begin
               if (handshake) begin
                  rr_ptr <= next_idx(winner);
                  if (lock_i[winner]) begin
                     state         <= LOCKED;
                     owner_o       <= winner;
                     lock_cnt      <= '0;
                     lock_active_o <= 1'b1;
                  end
               end
            end
            LOCKED: begin
               if (lock_cnt != CNT_MAX) lock_cnt <= lock_cnt + 1'b1;
               // rr_ptr already points past the owner, so exiting leaves it lowest priority.
               if ((handshake && !owner_lock) || (!owner_req && !owner_lock)) begin
                  state         <= ARB;
                  lock_active_o <= 1'b0;
               end else if (lock_cnt == CNT_MAX) begin
                  state         <= ARB;
                  lock_active_o <= 1'b0;
                  lock_abort_o  <= 1'b1;
               end
            end
            default: state <= ARB;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_periph_lock_rr_scheduler.sv
`default_nettype none
// ============================================================================
// tb_periph_lock_rr_scheduler : directed checks of rotation, stall, lock,
//                               watchdog and reset behaviour
// Revision : 1.0
// ============================================================================
module tb_periph_lock_rr_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req, lock;
   logic       sg;
   logic       slv_req;
   logic [1:0] sel;
   logic [3:0] gnt;
   logic       lock_active;
   logic [1:0] owner;
   logic       abort;

   logic [2:0] req3, lock3;
   logic       sg3;
   logic       slv_req3;
   logic [1:0] sel3;
   logic [2:0] gnt3;
   logic       lock_active3;
   logic [1:0] owner3;
   logic       abort3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   periph_lock_rr_scheduler #(.N_MASTER(4), .MAX_LOCK(8)) dut4 (
      .clk(clk), .rst(rst), .req_i(req), .lock_i(lock), .slv_gnt_i(sg),
      .slv_req_o(slv_req), .sel_o(sel), .gnt_o(gnt),
      .lock_active_o(lock_active), .owner_o(owner), .lock_abort_o(abort)
   );

   periph_lock_rr_scheduler #(.N_MASTER(3)) dut3 (
      .clk(clk), .rst(rst), .req_i(req3), .lock_i(lock3), .slv_gnt_i(sg3),
      .slv_req_o(slv_req3), .sel_o(sel3), .gnt_o(gnt3),
      .lock_active_o(lock_active3), .owner_o(owner3), .lock_abort_o(abort3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] rot4 [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
   logic [2:0] rot3 [7] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};

   initial begin
      rst = 1'b1; req = '0; lock = '0; sg = 1'b0;
      req3 = '0; lock3 = '0; sg3 = 1'b1;
      tick();
      tick();
      // no grant may escape while reset is held
      req = 4'b1111; sg = 1'b1; #1;
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_slv_req", 32'(slv_req), 32'h0);
      tick();
      rst = 1'b0; req = '0; sg = 1'b0; #1;
      check("idle_gnt", 32'(gnt), 32'h0);
      check("idle_slv_req", 32'(slv_req), 32'h0);
      check("idle_sel", 32'(sel), 32'h0);
      check("idle_lock_active", 32'(lock_active), 32'h0);
      check("idle_abort", 32'(abort), 32'h0);

      // rotation on both instances
      req = 4'b1111; sg = 1'b1; req3 = 3'b111; #1;
      for (int i = 0; i < 7; i++) begin
         check($sformatf("rot4_%0d", i), 32'(gnt), 32'(rot4[i]));
         check($sformatf("rot3_%0d", i), 32'(gnt3), 32'(rot3[i]));
         tick();
      end
      req3 = '0;

      // stall with rr_ptr=3: search wraps to master 0
      req = 4'b0011; sg = 1'b0; #1;
      check("stall_sel", 32'(sel), 32'h0);
      check("stall_gnt", 32'(gnt), 32'h0);
      check("stall_slv_req", 32'(slv_req), 32'h1);
      for (int i = 0; i < 2; i++) begin
         tick();
         check($sformatf("stall_sel_%0d", i), 32'(sel), 32'h0);
         check($sformatf("stall_gnt_%0d", i), 32'(gnt), 32'h0);
      end
      sg = 1'b1; #1;
      check("unstall_gnt", 32'(gnt), 32'b0001);
      tick();
      check("unstall_next", 32'(gnt), 32'b0010);
      tick();
      check("wrap_gnt", 32'(gnt), 32'b0001);
      tick();

      // lock by master 1 (rr_ptr=1)
      req = 4'b1010; lock = 4'b0010; sg = 1'b1; #1;
      check("lock_req_gnt", 32'(gnt), 32'b0010);
      check("lock_req_sel", 32'(sel), 32'h1);
      tick();
      check("lock_active", 32'(lock_active), 32'h1);
      check("lock_owner", 32'(owner), 32'h1);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("lock_xfer_%0d", i), 32'(gnt), 32'b0010);
         tick();
      end
      lock = 4'b0000; #1;
      check("release_xfer", 32'(gnt), 32'b0010);
      tick();
      check("release_lock_active", 32'(lock_active), 32'h0);
      check("release_abort", 32'(abort), 32'h0);
      check("release_next_gnt", 32'(gnt), 32'b1000);
      tick();

      // watchdog: master 2 locks and stalls past the limit
      req = 4'b0100; lock = 4'b0100; sg = 1'b1; #1;
      check("wd_entry_gnt", 32'(gnt), 32'b0100);
      tick();
      req = 4'b1100; sg = 1'b0; #1;
      check("wd_owner", 32'(owner), 32'h2);
      check("wd_sel", 32'(sel), 32'h2);
      check("wd_slv_req", 32'(slv_req), 32'h1);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("wd_active_%0d", i), 32'(lock_active), 32'h1);
         check($sformatf("wd_noabort_%0d", i), 32'(abort), 32'h0);
         check($sformatf("wd_gnt_%0d", i), 32'(gnt), 32'h0);
         tick();
      end
      check("wd_abort", 32'(abort), 32'h1);
      check("wd_lock_active", 32'(lock_active), 32'h0);
      check("wd_sel_after", 32'(sel), 32'h3);
      sg = 1'b1; #1;
      check("wd_next_gnt", 32'(gnt), 32'b1000);
      tick();
      check("wd_abort_one_cycle", 32'(abort), 32'h0);

      // relock by master 2, then reset mid-lock
      check("relock_gnt", 32'(gnt), 32'b0100);
      tick();
      check("relock_active", 32'(lock_active), 32'h1);
      check("relock_owner", 32'(owner), 32'h2);
      rst = 1'b1; req = 4'b1111; #1;
      check("midlock_rst_gnt", 32'(gnt), 32'h0);
      check("midlock_rst_slv_req", 32'(slv_req), 32'h0);
      tick();
      rst = 1'b0; lock = 4'b0000; #1;
      check("post_rst_active", 32'(lock_active), 32'h0);
      check("post_rst_owner", 32'(owner), 32'h0);
      check("post_rst_abort", 32'(abort), 32'h0);
      check("post_rst_gnt", 32'(gnt), 32'b0001);
      tick();
      check("post_rst_next_gnt", 32'(gnt), 32'b0010);
      check("post_rst_no_abort", 32'(abort), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
